// File: rtl/readout_sequencer.sv
// Reads nwords buffer words over the async read port and streams them MSB byte first
// on a valid/ready byte interface. Optional header (0xA5, nwords hi, nwords lo): READOUT_SEQUENCER_HEADER_EN.
module readout_sequencer #(
  parameter int DATBITS = 24,
  parameter int ADDBITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDBITS:0]   nwords,
  output logic               rd,
  output logic [ADDBITS-1:0] raddr,
  input  logic [DATBITS-1:0] rdata,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               done
);

  localparam int BYTES = DATBITS / 8;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES - 1);

`ifdef READOUT_SEQUENCER_HEADER_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_SEND, S_FIN} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_FIN} state_t;
`endif

  state_t             r_state, w_state_next;
  logic [DATBITS-1:0] r_shift, w_shift_next;
  logic [1:0]         r_idx, w_idx_next;
  logic [ADDBITS:0]   r_remaining, w_remaining_next;
  logic [ADDBITS-1:0] r_raddr, w_raddr_next;
  logic [7:0]         r_tx_data, w_tx_data_next;
  logic               r_rd, r_tx_valid, r_busy, r_done;
  logic               w_xfer;

`ifdef READOUT_SEQUENCER_HEADER_EN
  logic [15:0] w_nw16;
  assign w_nw16 = 16'(r_remaining);
`endif

  assign w_xfer = r_tx_valid & tx_ready;

  always_comb begin
    w_state_next     = r_state;
    w_shift_next     = r_shift;
    w_idx_next       = r_idx;
    w_remaining_next = r_remaining;
    w_raddr_next     = r_raddr;
    w_tx_data_next   = r_tx_data;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_remaining_next = nwords;
          w_raddr_next     = '0;
`ifdef READOUT_SEQUENCER_HEADER_EN
          w_idx_next     = 2'd0;
          w_tx_data_next = 8'hA5;
          w_state_next   = S_HDR;
`else
          w_state_next = (nwords == '0) ? S_FIN : S_LOAD;
`endif
        end
      end
`ifdef READOUT_SEQUENCER_HEADER_EN
      S_HDR: begin
        if (w_xfer) begin
          if (r_idx == 2'd2) begin
            w_state_next = (r_remaining == '0) ? S_FIN : S_LOAD;
          end else begin
            w_idx_next     = r_idx + 2'd1;
            w_tx_data_next = (r_idx == 2'd0) ? w_nw16[15:8] : w_nw16[7:0];
          end
        end
      end
`endif
      S_LOAD: begin
        w_shift_next   = rdata;
        w_idx_next     = 2'd0;
        w_tx_data_next = rdata[DATBITS-1 -: 8];
        w_state_next   = S_SEND;
      end
      S_SEND: begin
        if (w_xfer) begin
          if (r_idx == LAST_BYTE) begin
            w_remaining_next = r_remaining - (ADDBITS+1)'(1);
            // raddr may roll to 0 after the last word; it is not read again
            w_raddr_next     = r_raddr + ADDBITS'(1);
            w_state_next     = (r_remaining == (ADDBITS+1)'(1)) ? S_FIN : S_LOAD;
          end else begin
            w_idx_next     = r_idx + 2'd1;
            w_shift_next   = r_shift << 8;
            w_tx_data_next = w_shift_next[DATBITS-1 -: 8];
          end
        end
      end
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state implies.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_remaining <= '0;
      r_raddr     <= '0;
      r_tx_data   <= '0;
      r_rd        <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift     <= w_shift_next;
      r_idx       <= w_idx_next;
      r_remaining <= w_remaining_next;
      r_raddr     <= w_raddr_next;
      r_tx_data   <= w_tx_data_next;
      r_rd        <= (w_state_next == S_LOAD);
`ifdef READOUT_SEQUENCER_HEADER_EN
      r_tx_valid  <= (w_state_next == S_SEND) || (w_state_next == S_HDR);
`else
      r_tx_valid  <= (w_state_next == S_SEND);
`endif
      r_busy      <= (w_state_next != S_IDLE);
      r_done      <= (w_state_next == S_FIN);
    end
  end

  assign rd       = r_rd;
  assign raddr    = r_raddr;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer: byte order, cycle timing, stalls, boundary counts,
// ignored start, mid-readout reset; expectations follow READOUT_SEQUENCER_HEADER_EN when defined.
module tb_readout_sequencer;

  localparam int DW = 24;
  localparam int AW = 8;
`ifdef READOUT_SEQUENCER_HEADER_EN
  localparam int HDR_N = 3;
`else
  localparam int HDR_N = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, tx_ready;
  logic [AW:0]   nwords;
  logic          rd, tx_valid, busy, done;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic [7:0]    tx_data;

  logic [DW-1:0] mem [0:255];
  logic [7:0]    bytes_q[$];
  logic [7:0]    exp_q[$];
  logic [AW-1:0] rd_q[$];
  int            done_cnt;
  int            n_checks = 0;
  int            n_fail = 0;

  readout_sequencer #(.DATBITS(DW), .ADDBITS(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .nwords(nwords),
    .rd(rd), .raddr(raddr), .rdata(rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  // Buffer model: drives the bus only while rd is high.
  assign rdata = rd ? mem[raddr] : {DW{1'bz}};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transfer/bus monitor, sampled mid-cycle.
  initial begin
    logic       stall_prev;
    logic [7:0] stall_data;
    logic       rd_prev;
    stall_prev = 1'b0;
    stall_data = 8'h00;
    rd_prev    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
        rd_prev    = 1'b0;
      end else begin
        if (tx_valid && tx_ready) bytes_q.push_back(tx_data);
        if (stall_prev) begin
          chk("stall_valid_held", {31'd0, tx_valid}, 32'd1);
          chk("stall_data_held", {24'd0, tx_data}, {24'd0, stall_data});
        end
        stall_prev = tx_valid && !tx_ready;
        stall_data = tx_data;
        if (rd) begin
          rd_q.push_back(raddr);
          chk("rd_with_valid", {31'd0, tx_valid}, 32'd0);
          chk("rd_two_cycles", {31'd0, rd_prev}, 32'd0);
        end
        rd_prev = rd;
        if (done) done_cnt++;
      end
    end
  end

  task automatic clear_obs();
    bytes_q.delete();
    rd_q.delete();
    done_cnt = 0;
  endtask

  task automatic build_exp(input int n);
    logic [DW-1:0] w;
    exp_q.delete();
    if (HDR_N != 0) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'((n >> 8) & 255));
      exp_q.push_back(8'(n & 255));
    end
    for (int i = 0; i < n; i++) begin
      w = mem[i];
      for (int k = 0; k < DW / 8; k++) exp_q.push_back(w[DW-1-8*k -: 8]);
    end
  endtask

  task automatic cmp_stream(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_len"}, bytes_q.size(), exp_q.size());
    for (int i = 0; i < bytes_q.size() && i < exp_q.size(); i++)
      if (bytes_q[i] !== exp_q[i]) bad++;
    chk({tag, "_bytes_wrong"}, bad, 0);
  endtask

  task automatic cmp_addr(input string tag, input int n);
    int bad;
    bad = 0;
    chk({tag, "_reads"}, rd_q.size(), n);
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i] !== AW'(i)) bad++;
    chk({tag, "_addr_wrong"}, bad, 0);
  endtask

  task automatic wait_done(input bit rnd, input int budget);
    int cyc;
    cyc = 0;
    while (!done && cyc < budget) begin
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    if (!done) chk("done_timeout", 32'd1, 32'd0);
    tx_ready = 1'b1;
    step();
  endtask

  task automatic run_readout(input int n, input bit rnd);
    nwords = (AW+1)'(n);
    start  = 1'b1;
    step();
    start  = 1'b0;
    wait_done(rnd, 5000);
  endtask

  initial begin
    int first_valid, first_rd, done_cyc;
    rst = 1'b1; start = 1'b0; nwords = '0; tx_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = {8'(i), 8'(~i), 8'(i ^ 8'h5A)};
    mem[0] = 24'h123456;
    mem[1] = 24'hABCDEF;
    clear_obs();
    repeat (3) step();

    chk("rst_rd", {31'd0, rd}, 32'd0);
    chk("rst_raddr", {24'd0, raddr}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    step();

    // Two words, ready held high: cycle-exact timing.
    clear_obs();
    build_exp(2);
    nwords = 9'd2; start = 1'b1;
    step();
    start = 1'b0;
    first_valid = 0; first_rd = 0; done_cyc = 0;
    for (int c = 1; c <= 16; c++) begin
      if (tx_valid && first_valid == 0) first_valid = c;
      if (rd && first_rd == 0) first_rd = c;
      if (done && done_cyc == 0) done_cyc = c;
      if (c == 1) chk("c1_busy", {31'd0, busy}, 32'd1);
      step();
    end
    chk("first_load_cycle", first_rd, 1 + HDR_N);
    chk("first_valid_cycle", first_valid, (HDR_N != 0) ? 1 : 2);
    chk("done_cycle", done_cyc, 9 + HDR_N);
    chk("done_count", done_cnt, 1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    cmp_stream("basic");
    cmp_addr("basic", 2);

    // Same data with random stalls.
    clear_obs();
    run_readout(2, 1'b1);
    cmp_stream("stall");
    cmp_addr("stall", 2);
    chk("stall_done_count", done_cnt, 1);

    // nwords = 0: straight to FIN (after the header, if any).
    clear_obs();
    build_exp(0);
    nwords = 9'd0; start = 1'b1;
    step();
    start = 1'b0;
    done_cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      if (done && done_cyc == 0) done_cyc = c;
      step();
    end
    chk("zero_done_cycle", done_cyc, 1 + HDR_N);
    cmp_stream("zero");
    chk("zero_reads", rd_q.size(), 0);

    // start pulsed while busy must be ignored.
    clear_obs();
    build_exp(2);
    nwords = 9'd2; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    nwords = 9'd5; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(1'b0, 200);
    repeat (8) step();
    cmp_stream("ignored_start");
    cmp_addr("ignored_start", 2);
    chk("ignored_done_count", done_cnt, 1);

    // Reset during the second byte of word 1, then restart.
    clear_obs();
    nwords = 9'd2; start = 1'b1;
    step();
    start = 1'b0;
    repeat (6 + HDR_N) step();
    chk("pre_rst_byte", {24'd0, tx_data}, 32'h0000_00CD);
    rst = 1'b1;
    step();
    chk("mrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_rd", {31'd0, rd}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("mrst_raddr", {24'd0, raddr}, 32'd0);
    rst = 1'b0;
    repeat (4) step();
    chk("mrst_no_done", done_cnt, 0);
    clear_obs();
    build_exp(1);
    run_readout(1, 1'b0);
    cmp_stream("restart");
    cmp_addr("restart", 1);

    // Full address space: 256 words, 768 data bytes.
    clear_obs();
    build_exp(256);
    run_readout(256, 1'b0);
    cmp_stream("full");
    cmp_addr("full", 256);
    chk("full_raddr_after", {24'd0, raddr}, 32'd0);
    chk("full_done_count", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
